// File: rtl/uart_pkg.sv
// Shared types for the UART transmit engine.
//   tx_state_t  : transmit FSM states
//   frame_cfg_t : per-frame format snapshot (data width, parity, stop bits)
//   frame_parity: parity bit for a byte under a given frame format
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef struct packed {
        logic eight;     // 1 = 8 data bits, 0 = 7
        logic pen;       // parity enable
        logic ohel;      // parity sense
        logic two_stop;  // 1 = two stop bits
    } frame_cfg_t;

    // Bit 7 only contributes when the frame carries 8 data bits.
    function automatic logic frame_parity(input logic [7:0] data, input frame_cfg_t cfg);
        logic p;
        p = ^data[6:0];
        if (cfg.eight) begin
            p = p ^ data[7];
        end
        case (cfg.ohel)
            PARITY_EVEN: return p;
            PARITY_ODD:  return ~p;
            default:     return p;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO.
//   clk, reset : clock, synchronous active-high flush
//   push/wr_data : write request; ignored while full
//   pop/rd_data  : rd_data shows the head entry; pop ignored while empty
//   count, full, empty : occupancy status (registered)
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        // DEPTH is a power of two, so pointer wrap is plain overflow.
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_engine.sv
// Buffered UART transmitter with run-time frame format and threshold interrupt.
//   clk, reset         : 100 MHz clock, synchronous active-high reset
//   baud_div           : clk cycles per bit (0 behaves as 1)
//   eight/pen/ohel/two_stop : frame format, sampled when a byte is popped
//   wr_en, wr_data     : byte push from the port decoder
//   int_ack            : clears int_req and ovf
//   tx                 : serial line (idle high, registered)
//   txrdy, busy, fifo_count : flow-control status
//   int_req, ovf       : sticky threshold interrupt and overflow flags
module uart_tx_fifo_engine
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 19,
    parameter int unsigned INT_THRESH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          eight,
    input  logic                          pen,
    input  logic                          ohel,
    input  logic                          two_stop,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          int_ack,
    output logic                          tx,
    output logic                          txrdy,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          int_req,
    output logic                          ovf
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t        state_q, state_d;
    frame_cfg_t       cfg_q, cfg_d;
    logic [7:0]       data_q, data_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic             stop2_q, stop2_d;   // second stop period in progress
    logic             tx_q, tx_d;
    logic             int_req_q, int_req_d;
    logic             ovf_q, ovf_d;

    logic             fifo_pop;
    logic [7:0]       fifo_rd;
    logic             fifo_full, fifo_empty;
    logic             bit_end, wr_accept, thresh_hit;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        data_d   = data_q;
        div_d    = div_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        stop2_d  = stop2_q;
        fifo_pop = 1'b0;
        bit_end  = (baud_q == '0);

        if (state_q != IDLE) begin
            baud_d = bit_end ? (div_q - DIV_W'(1)) : (baud_q - DIV_W'(1));
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_d   = fifo_rd;
                    cfg_d    = '{eight: eight, pen: pen, ohel: ohel, two_stop: two_stop};
                    div_d    = (baud_div == '0) ? DIV_W'(1) : baud_div;
                    baud_d   = div_d - DIV_W'(1);
                    bit_d    = '0;
                    stop2_d  = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == (cfg_q.eight ? 3'd7 : 3'd6)) begin
                        state_d = cfg_q.pen ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (cfg_q.two_stop && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is registered from the current state, so tx trails
        // the state register by one clk (pop at k+1, start bit at k+2).
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_q[bit_q];
            PARITY:  tx_d = frame_parity(data_q, cfg_q);
            default: tx_d = 1'b1;
        endcase

        wr_accept  = wr_en && !fifo_full;
        thresh_hit = fifo_pop && !wr_accept && (fifo_count == CW'(INT_THRESH + 1));
        int_req_d  = thresh_hit || (int_req_q && !int_ack);
        ovf_d      = (wr_en && fifo_full) || (ovf_q && !int_ack);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            data_q    <= '0;
            div_q     <= '0;
            baud_q    <= '0;
            bit_q     <= '0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            int_req_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            data_q    <= data_d;
            div_q     <= div_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            int_req_q <= int_req_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tx      = tx_q;
    assign txrdy   = !fifo_full;
    assign busy    = (state_q != IDLE) || (fifo_count != '0);
    assign int_req = int_req_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// Directed self-checking bench for uart_tx_fifo_engine (FIFO_DEPTH=16, INT_THRESH=4).
module tb_uart_tx_fifo_engine;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DIV_W  = 19;
    localparam int unsigned THRESH = 4;
    localparam int          B      = 4;   // bit period used by most tests

    logic             clk = 1'b0;
    logic             reset;
    logic [DIV_W-1:0] baud_div;
    logic             eight, pen, ohel, two_stop;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             int_ack;
    logic             tx, txrdy, busy, int_req, ovf;
    logic [4:0]       fifo_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_engine #(
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (DIV_W),
        .INT_THRESH (THRESH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_div   (baud_div),
        .eight      (eight),
        .pen        (pen),
        .ohel       (ohel),
        .two_stop   (two_stop),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .int_ack    (int_ack),
        .tx         (tx),
        .txrdy      (txrdy),
        .busy       (busy),
        .fifo_count (fifo_count),
        .int_req    (int_req),
        .ovf        (ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Returns at the first negedge where tx is low (possibly the current one).
    task automatic wait_low(input int limit, output int waited);
        waited = 0;
        while (tx !== 1'b0 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        if (tx !== 1'b0) check_eq("start_bit_timeout", tx, 0);
    endtask

    // Samples n bits at mid-period (period B); returns on the frame's last clk.
    task automatic rx_bits(input int n, output logic [11:0] bits, output int waited);
        bits = '0;
        wait_low(2000, waited);
        repeat (B / 2) @(negedge clk);
        bits[0] = tx;
        for (int i = 1; i < n; i++) begin
            repeat (B) @(negedge clk);
            bits[i] = tx;
        end
        repeat (B - 1 - B / 2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0]  f10;
        logic [11:0] bits;
        int          w, bad, lows;

        reset = 1'b1; baud_div = DIV_W'(B); eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        two_stop = 1'b0; wr_en = 1'b0; wr_data = '0; int_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_txrdy", txrdy, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_int_req", int_req, 0);
        check_eq("rst_ovf", ovf, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: 8N1, 0xA5, exact latency and per-clk waveform
        f10 = {1'b1, 8'hA5, 1'b0};
        push(8'hA5);
        check_eq("t1_tx_edge_k", tx, 1);
        @(negedge clk);
        check_eq("t1_popped", fifo_count, 0);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_tx_edge_k1", tx, 1);
        @(negedge clk);
        check_eq("t1_start_edge_k2", tx, 0);
        bad = 0;
        for (int c = 1; c < 10 * B; c++) begin
            @(negedge clk);
            if (tx !== f10[c / B]) bad++;
        end
        check_eq("t1_bad_cycles", bad, 0);
        @(negedge clk);
        check_eq("t1_idle_tx", tx, 1);
        check_eq("t1_idle_busy", busy, 0);

        // baud_div=0 behaves as a one-clk bit period
        baud_div = '0;
        f10 = {1'b1, 8'h5A, 1'b0};
        push(8'h5A);
        @(negedge clk);
        @(negedge clk);
        check_eq("div0_start", tx, 0);
        bad = 0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (tx !== f10[c]) bad++;
        end
        check_eq("div0_bad_cycles", bad, 0);
        @(negedge clk);
        check_eq("div0_idle_busy", busy, 0);
        baud_div = DIV_W'(B);

        // 2: 7 data bits, odd parity; config changed mid-frame must not matter
        eight = 1'b0; pen = 1'b1; ohel = 1'b1;
        push(8'h41);
        @(negedge clk);
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        rx_bits(10, bits, w);
        check_eq("t2_7o1_frame", bits[9:0], {1'b1, 1'b1, 7'h41, 1'b0});
        // even parity, bit 7 set but ignored in 7-bit mode
        eight = 1'b0; pen = 1'b1; ohel = 1'b0;
        push(8'hC1);
        rx_bits(10, bits, w);
        check_eq("t2_7e1_frame", bits[9:0], {1'b1, 1'b0, 7'h41, 1'b0});
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        repeat (4) @(negedge clk);

        // 3: first byte goes straight to the shifter, then 16 fill the FIFO
        push(8'h00);
        @(negedge clk);
        check_eq("t3_first_popped", fifo_count, 0);
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        check_eq("t3_full_txrdy", txrdy, 0);
        check_eq("t3_full_count", fifo_count, 16);
        check_eq("t3_no_ovf_yet", ovf, 0);
        push(8'hEE);
        check_eq("t3_ovf_set", ovf, 1);
        check_eq("t3_count_held", fifo_count, 16);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        check_eq("t3_ovf_cleared", ovf, 0);
        check_eq("t3_int_req_idle", int_req, 0);

        // 4: drain; int_req on the 5->4 pop, with int_ack held on that edge
        fork
            begin
                logic [11:0] rb;
                logic [7:0]  eb;
                int          rw, guard, nlow;
                guard = 0;
                while (fifo_count != 5'd15 && guard < 1000) begin
                    @(negedge clk);
                    guard++;
                end
                check_eq("t4_second_pop", fifo_count, 15);
                for (int i = 0; i < 16; i++) begin
                    rx_bits(10, rb, rw);
                    eb = 8'h10 + 8'(i);
                    check_eq($sformatf("t4_byte%0d", i), rb[9:0], {1'b1, eb, 1'b0});
                end
                nlow = 0;
                repeat (200) begin
                    @(negedge clk);
                    if (tx === 1'b0) nlow++;
                end
                check_eq("t4_dropped_byte_absent", nlow, 0);
                check_eq("t4_drained_count", fifo_count, 0);
                check_eq("t4_drained_busy", busy, 0);
            end
            begin
                int  cyc;
                logic seen5, done;
                seen5 = 1'b0; done = 1'b0; cyc = 0;
                while (!done && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    if (!seen5 && fifo_count == 5'd5) begin
                        check_eq("t4_no_early_int", int_req, 0);
                        int_ack = 1'b1;
                        seen5 = 1'b1;
                    end else if (seen5 && fifo_count == 5'd4) begin
                        check_eq("t4_set_wins_over_ack", int_req, 1);
                        int_ack = 1'b0;
                        @(negedge clk);
                        check_eq("t4_int_sticky", int_req, 1);
                        int_ack = 1'b1;
                        @(negedge clk);
                        int_ack = 1'b0;
                        check_eq("t4_int_acked", int_req, 0);
                        done = 1'b1;
                    end
                end
                int_ack = 1'b0;
                if (!done) check_eq("t4_int_window_timeout", fifo_count, 4);
            end
        join

        // 5: two stop bits, three back-to-back frames
        two_stop = 1'b1;
        push(8'h3C);
        push(8'hC3);
        push(8'h81);
        check_eq("t5_busy", busy, 1);
        rx_bits(11, bits, w);
        check_eq("t5_frame0", bits[10:0], {2'b11, 8'h3C, 1'b0});
        rx_bits(11, bits, w);
        check_eq("t5_frame1", bits[10:0], {2'b11, 8'hC3, 1'b0});
        check_eq("t5_gap1", w, 2);
        rx_bits(11, bits, w);
        check_eq("t5_frame2", bits[10:0], {2'b11, 8'h81, 1'b0});
        check_eq("t5_gap2", w, 2);
        check_eq("t5_busy_after_stop", busy, 0);
        @(negedge clk);
        check_eq("t5_idle_tx", tx, 1);
        two_stop = 1'b0;
        repeat (4) @(negedge clk);

        // 6: reset in the middle of DATA with five bytes queued
        for (int i = 0; i < 6; i++) push(8'h00);
        check_eq("t6_queued", fifo_count, 5);
        repeat (6) @(negedge clk);
        check_eq("t6_mid_data_tx", tx, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("t6_rst_tx", tx, 1);
        check_eq("t6_rst_count", fifo_count, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_txrdy", txrdy, 1);
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx === 1'b0) lows++;
        end
        check_eq("t6_no_frames", lows, 0);
        check_eq("t6_int_req", int_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_engine.md
Name: uart_tx_fifo_engine

Overview:
Parametrised successor to the single-byte transmit engine. A write-side FIFO buffers bytes from the TramelBlaze output port. The block serialises them with a run-time selectable frame format: 7/8 data bits, optional even/odd parity, and 1 or 2 stop bits. It raises a level-threshold interrupt for the processor's SR-latched interrupt path. It sits between the port address decoder (write strobe) and the TX pin.

Parameters:
FIFO_DEPTH, 16, entries in TX FIFO; power of 2, at least 2
DIV_W, 19, width of baud divisor
INT_THRESH, 4, int_req fires when fifo_count falls from above INT_THRESH to INT_THRESH or below; must be less than FIFO_DEPTH

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high reset
baud_div  in  DIV_W  bit period in clk cycles; 0 is treated as 1
eight  in  1  1 = 8 data bits, 0 = 7
pen  in  1  parity enable
ohel  in  1  parity sense: 0 = even, 1 = odd
two_stop  in  1  1 = two stop bits
wr_en  in  1  push wr_data (port-decode AND write strobe)
wr_data  in  8  byte to send; bit 7 is ignored when eight=0
int_ack  in  1  clears int_req and ovf
tx  out  1  serial line, idle high
txrdy  out  1  FIFO not full
busy  out  1  frame in progress or FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
int_req  out  1  sticky threshold interrupt
ovf  out  1  sticky overflow (write while full)

Behaviour:
- Reset values: tx=1, txrdy=1, busy=0, fifo_count=0, int_req=0, ovf=0. FSM goes to IDLE, FIFO is flushed, baud and bit counters clear. Reset mid-frame aborts the frame: tx=1 from the edge after reset is sampled high.
- FIFO: synchronous, first-word fall-through.
  - Write is accepted iff wr_en && !full, with full evaluated before the edge.
  - Write while full: data dropped, ovf set. This holds even if a pop occurs on the same edge.
  - Simultaneous accepted write and pop: fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If FIFO is non-empty: pop, latch byte and a config snapshot (eight, pen, ohel, two_stop, baud_div), go to START.
  - START: tx=0 for one bit period, then DATA.
  - DATA: LSB-first. Sends 8 bits if eight, else 7. Then PARITY if pen, else STOP.
  - PARITY: tx = XOR of sent data bits, XOR ohel. One bit period.
  - STOP: tx=1 for 1 or 2 bit periods. Then IDLE, which may pop the next byte on the very next cycle (back-to-back frames have no extra idle gap beyond one clk).
- Latency: wr_en at edge k into an empty FIFO in IDLE gives pop at edge k+1; tx falls at edge k+2.
- Bit period: a baud counter reloads to baud_div-1 on every bit boundary and decrements. Bit advance happens at count 0. Counter width is DIV_W with no overflow.
- Config inputs change only affects the next frame. Mid-frame changes are ignored.
- Frame length in bits: 1 + (7|8) + pen + (1|2), range 9..12.
- int_req: set on the edge where fifo_count goes from INT_THRESH+1 to INT_THRESH (pop, no write). Cleared by int_ack. Set and ack on the same edge: set wins.
- ovf: cleared by int_ack unless a new overflow occurs on the same edge.
- busy = (state != IDLE) || (fifo_count != 0).

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - PARITY_EVEN=0 / PARITY_ODD=1 constants
  - frame-config struct {eight, pen, ohel, two_stop}
- One sub-module: uart_sync_fifo (parametrised width/depth, count output, full/empty).
- Engine FSM, baud counter and interrupt logic stay in the top.

Test Plan:
1. baud_div=4, eight=1, pen=0, two_stop=0; write 8'hA5 -> tx: 0, 1,0,1,0,0,1,0,1, 1. Each bit 4 clks, 40 clks total. tx low at edge k+2.
2. eight=0, pen=1, ohel=1, write 8'h41 -> 7 data bits 1000001, parity = 0^1 = 1, then stop. Repeat with ohel=0 -> parity 0.
3. Burst 16 writes then a 17th write (FIFO_DEPTH=16) -> txrdy=0 after the 16th, ovf=1, 17th byte never appears. int_ack clears ovf.
4. Drain a full FIFO -> int_req rises exactly when fifo_count reaches 4. Assert int_ack on that same edge -> int_req stays 1.
5. two_stop=1, three queued bytes -> each frame has 2 stop periods, next start bit exactly one clk after the last stop, busy falls after the final stop.
6. Assert reset mid-DATA with 5 bytes queued -> tx=1, fifo_count=0 and state IDLE on the next edge. No further frames are sent.
